frame_fifo: RTL and testbench
=============================

# frame_fifo

Parametrised frame store between the TPIU frame collector and the output handler, successor to the fixed 128-bit/512-deep frame buffer. It accepts frames flagged by an asynchronous toggle and presents them upstream through a first-word-fall-through valid/ready port. Overflow policy is selectable at run time: drop-newest, or overwrite-oldest for post-mortem capture. It also provides a synchronous flush, a sticky overflow flag and a stretched activity indicator.

## Interface
- FRAME_W, 128, frame width in bits
- DEPTH_LOG2, 9, log2 of total capacity in frames (≥2); capacity CAP = 2^DEPTH_LOG2
- STRETCH_W, 26, width of activity-stretch counter
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_toggle  in  1  async; every transition (either edge) marks one new frame on in_data
- in_data  in  FRAME_W  frame; stable from 1 clk before a toggle until 4 clks after it
- ovf_mode  in  1  0 = drop newest on full, 1 = overwrite oldest
- flush  in  1  synchronous; discard all stored frames
- clr_ovf  in  1  clears ovf_sticky (and stats when compiled in)
- out_data  out  FRAME_W  head frame, valid while out_valid
- out_valid  out  1  head frame present
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- level  out  DEPTH_LOG2+1  frames held, 0..CAP
- full  out  1  level == CAP
- ovf_sticky  out  1  set on any lost/overwritten frame
- activity  out  1  stretch counter non-zero
- total_frames, lost_frames  out  32 each  stats (see Configuration)
- high_water  out  DEPTH_LOG2+1  max level since clear (see Configuration)

## Operation
- Sync: in_toggle goes through 2 flops and an edge-detect flop; a differing sync pair asserts an internal wr strobe for exactly one cycle.
- Storage: dual-port synchronous RAM plus an output stage; level counts both. Head is always the oldest retained frame.
- Write, not full: store frame, level+1.
- Write, full, pop same cycle: no loss; level unchanged.
- Write, full, no pop, ovf_mode=0: frame discarded; lost+1, ovf_sticky=1.
- Write, full, no pop, ovf_mode=1: oldest frame not in the output stage is discarded, new frame stored; level stays CAP; lost+1, ovf_sticky=1. The presented head is never changed while out_valid=1.
- Pop: out_valid & out_ready; level-1; next frame falls through.
- flush: pointers, level and out_valid go to 0 on the next edge. A write in the same cycle is discarded and not counted as lost (total still counts). Flush does not clear ovf_sticky or the stats.
- clr_ovf with a simultaneous overflow: set wins.
- activity: every wr strobe reloads the counter to all ones; otherwise it decrements to 0 and holds.
- Pointers wrap modulo CAP; level arithmetic is exact over 0..CAP.

## Timing
- Reset values: out_valid 0, out_data 0, level 0, full 0, ovf_sticky 0, activity 0, all stats 0, sync flops 0.
- in_toggle edge to wr strobe: 3 clk edges.
- Write into an empty FIFO: out_valid rises 2 clocks after the write edge.
- Sustained throughput: 1 frame per clk in and out. Back-to-back pops with out_ready held high deliver one frame per cycle while level ≥ 2.
- level/full update on the same edge as the write or pop. ovf_sticky sets on the loss edge.
- An async rst mid-stream clears everything immediately. No partial frame survives.

## Configuration
- FRAME_FIFO_STATS_EN defined: total_frames counts every wr strobe and lost_frames counts every dropped or overwritten frame, both saturating at 2^32-1. high_water tracks max level. clr_ovf zeroes all three.
- Not defined: total_frames, lost_frames and high_water tie to 0 and their logic is removed. All other behaviour is identical.

## Test plan
(DEPTH_LOG2=3, CAP=8, STATS_EN defined)
- Toggle in_toggle 3 times with data 0x11,0x22,0x33 and out_ready=0 -> level=3, out_valid=1, out_data=0x11. Then hold out_ready=1 -> 0x11,0x22,0x33 on consecutive cycles, level=0.
- ovf_mode=0, write 10 frames 1..10 with no pop -> level=8, full=1, lost_frames=2, ovf_sticky=1. Drain yields 1..8.
- ovf_mode=1, write 10 frames 1..10 with no pop -> head stays 1, lost_frames=2. Drain yields 1,4,5,6,7,8,9,10.
- Full FIFO, write coincident with pop -> no loss, level stays 8, lost_frames unchanged.
- flush coincident with wr strobe at level=5 -> next cycle level=0, out_valid=0, total_frames+1, lost_frames unchanged.
- Assert rst mid-burst at level=4 -> all outputs at reset values immediately. Later toggles are stored normally, and activity asserts 3 clks after a toggle.

Source files
------------

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - frame store with toggle-flagged input, FWFT output and selectable overflow policy
// Optional statistics counters are compiled in with FRAME_FIFO_STATS_EN.
module frame_fifo #(
    parameter int FRAME_W    = 128,
    parameter int DEPTH_LOG2 = 9,
    parameter int STRETCH_W  = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_toggle,
    input  logic [FRAME_W-1:0]    in_data,
    input  logic                  ovf_mode,
    input  logic                  flush,
    input  logic                  clr_ovf,
    output logic [FRAME_W-1:0]    out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  ovf_sticky,
    output logic                  activity,
    output logic [31:0]           total_frames,
    output logic [31:0]           lost_frames,
    output logic [DEPTH_LOG2:0]   high_water
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam int CAP = 1 << DEPTH_LOG2;
    localparam logic [LW-1:0] CAP_L = LW'(CAP);

    logic                  tog0, tog1, tog2, wr;
    logic [FRAME_W-1:0]    mem [CAP];
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [LW-1:0]         ramCnt, levelQ, levelNext;
    logic                  midValid, outValid;
    logic [FRAME_W-1:0]    midData, outData;
    logic                  stickyQ;
    logic [STRETCH_W-1:0]  stretchCnt;

    logic pop, isFull, wrAccept, lose, dropOldest;
    logic outFree, midMove, midStay, dropMid, dropRam, rd, ramPop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tog0 <= 1'b0;
            tog1 <= 1'b0;
            tog2 <= 1'b0;
        end else begin
            tog0 <= in_toggle;
            tog1 <= tog0;
            tog2 <= tog1;
        end
    end

    assign wr     = tog1 ^ tog2;
    assign pop    = outValid & out_ready;
    assign isFull = (levelQ == CAP_L);

    // Storage is a chain RAM -> mid (RAM read register) -> out. On overwrite the
    // victim is the oldest frame that will not be sitting in the out stage.
    always_comb begin
        wrAccept   = 1'b0;
        lose       = 1'b0;
        dropOldest = 1'b0;
        if (wr && !flush) begin
            if (!isFull || pop) begin
                wrAccept = 1'b1;
            end else if (ovf_mode) begin
                wrAccept   = 1'b1;
                dropOldest = 1'b1;
                lose       = 1'b1;
            end else begin
                lose = 1'b1;
            end
        end
        outFree = !outValid || pop;
        midMove = midValid && outFree;
        midStay = midValid && !midMove;
        dropMid = dropOldest && midStay;
        dropRam = dropOldest && !midStay && (ramCnt != '0);
        rd      = (ramCnt != '0) && (!midStay || dropMid) && !dropRam;
        ramPop  = rd || dropRam;
        if (flush)
            levelNext = '0;
        else
            levelNext = levelQ + LW'(wrAccept) - LW'(pop) - LW'(dropOldest);
    end

    always_ff @(posedge clk) begin
        if (wrAccept)
            mem[wrPtr] <= in_data;
        if (rd)
            midData <= mem[rdPtr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            ramCnt   <= '0;
            midValid <= 1'b0;
            outValid <= 1'b0;
            outData  <= '0;
            levelQ   <= '0;
        end else begin
            levelQ <= levelNext;
            if (flush) begin
                wrPtr    <= '0;
                rdPtr    <= '0;
                ramCnt   <= '0;
                midValid <= 1'b0;
                outValid <= 1'b0;
            end else begin
                if (wrAccept)
                    wrPtr <= wrPtr + 1'b1;
                if (ramPop)
                    rdPtr <= rdPtr + 1'b1;
                ramCnt <= ramCnt + LW'(wrAccept) - LW'(ramPop);
                if (rd)
                    midValid <= 1'b1;
                else if (midMove || dropMid)
                    midValid <= 1'b0;
                if (midMove) begin
                    outValid <= 1'b1;
                    outData  <= midData;
                end else if (pop) begin
                    outValid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stickyQ    <= 1'b0;
            stretchCnt <= '0;
        end else begin
            if (lose)
                stickyQ <= 1'b1;
            else if (clr_ovf)
                stickyQ <= 1'b0;
            if (wr)
                stretchCnt <= '1;
            else if (stretchCnt != '0)
                stretchCnt <= stretchCnt - STRETCH_W'(1);
        end
    end

`ifdef FRAME_FIFO_STATS_EN
    logic [31:0]   totalCnt, lostCnt;
    logic [LW-1:0] hwMark;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            totalCnt <= '0;
            lostCnt  <= '0;
            hwMark   <= '0;
        end else if (clr_ovf) begin
            totalCnt <= '0;
            lostCnt  <= '0;
            hwMark   <= '0;
        end else begin
            if (wr && totalCnt != '1)
                totalCnt <= totalCnt + 32'd1;
            if (lose && lostCnt != '1)
                lostCnt <= lostCnt + 32'd1;
            if (levelNext > hwMark)
                hwMark <= levelNext;
        end
    end

    assign total_frames = totalCnt;
    assign lost_frames  = lostCnt;
    assign high_water   = hwMark;
`else
    assign total_frames = '0;
    assign lost_frames  = '0;
    assign high_water   = '0;
`endif

    assign out_data   = outData;
    assign out_valid  = outValid;
    assign level      = levelQ;
    assign full       = isFull;
    assign ovf_sticky = stickyQ;
    assign activity   = (stretchCnt != '0);

endmodule

// File: tb/tb_frame_fifo.sv
// tb/tb_frame_fifo.sv - directed scoreboard bench for frame_fifo (CAP=8)
module tb_frame_fifo;

    localparam int FW = 16;
    localparam int DL = 3;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_toggle = 1'b0;
    logic [FW-1:0] in_data = '0;
    logic          ovf_mode = 1'b0;
    logic          flush = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_data;
    logic          out_valid;
    logic [DL:0]   level;
    logic          full;
    logic          ovf_sticky;
    logic          activity;
    logic [31:0]   total_frames;
    logic [31:0]   lost_frames;
    logic [DL:0]   high_water;

    frame_fifo #(.FRAME_W(FW), .DEPTH_LOG2(DL), .STRETCH_W(SW)) dut (
        .clk(clk), .rst(rst), .in_toggle(in_toggle), .in_data(in_data),
        .ovf_mode(ovf_mode), .flush(flush), .clr_ovf(clr_ovf),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .full(full), .ovf_sticky(ovf_sticky), .activity(activity),
        .total_frames(total_frames), .lost_frames(lost_frames), .high_water(high_water)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] expQ[$];
    logic [31:0] totalSnap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] st(input logic [63:0] v);
`ifdef FRAME_FIFO_STATS_EN
        return v;
`else
        return 64'(v & 64'd0);
`endif
    endfunction

    // Scoreboard monitor: every accepted head frame must match the next expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                logic [FW-1:0] e;
                e = expQ.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", out_data, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [FW-1:0] d);
        in_data = d;
        cyc(1);
        in_toggle = ~in_toggle;
        cyc(4);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && level != 0; i++)
            cyc(1);
        out_ready = 1'b0;
        check("drain_level", 64'(level), 0);
        check("drain_queue_empty", 64'(expQ.size()), 0);
    endtask

    task automatic pulseClr();
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        cyc(1);
    endtask

    initial begin
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_level", 64'(level), 0);
        check("rst_full", 64'(full), 0);
        check("rst_sticky", 64'(ovf_sticky), 0);
        check("rst_activity", 64'(activity), 0);
        check("rst_total", 64'(total_frames), 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // three frames, then back-to-back drain
        sendFrame(16'h11); sendFrame(16'h22); sendFrame(16'h33);
        check("t1_level", 64'(level), 3);
        check("t1_valid", 64'(out_valid), 1);
        check("t1_head", 64'(out_data), 64'h11);
        expQ.push_back(16'h11); expQ.push_back(16'h22); expQ.push_back(16'h33);
        out_ready = 1'b1;
        cyc(3);
        out_ready = 1'b0;
        check("t1_level_after_3", 64'(level), 0);
        check("t1_queue_empty", 64'(expQ.size()), 0);
        cyc(20);
        check("t1_activity_decay", 64'(activity), 0);

        // drop-newest overflow
        ovf_mode = 1'b0;
        for (int i = 1; i <= 10; i++) sendFrame(FW'(i));
        check("t2_level", 64'(level), 8);
        check("t2_full", 64'(full), 1);
        check("t2_sticky", 64'(ovf_sticky), 1);
        check("t2_lost", 64'(lost_frames), st(2));
        check("t2_total", 64'(total_frames), st(13));
        check("t2_high_water", 64'(high_water), st(8));
        for (int i = 1; i <= 8; i++) expQ.push_back(FW'(i));
        drain();
        pulseClr();
        check("clr_sticky", 64'(ovf_sticky), 0);
        check("clr_lost", 64'(lost_frames), 0);
        check("clr_high_water", 64'(high_water), 0);

        // overwrite-oldest overflow
        ovf_mode = 1'b1;
        for (int i = 1; i <= 10; i++) sendFrame(FW'(i));
        check("t3_level", 64'(level), 8);
        check("t3_head", 64'(out_data), 1);
        check("t3_sticky", 64'(ovf_sticky), 1);
        check("t3_lost", 64'(lost_frames), st(2));
        expQ.push_back(FW'(1));
        for (int i = 4; i <= 10; i++) expQ.push_back(FW'(i));
        drain();

        // full FIFO, write coincident with pop
        pulseClr();
        ovf_mode = 1'b0;
        for (int i = 1; i <= 8; i++) sendFrame(FW'(i));
        check("t4_full_before", 64'(full), 1);
        expQ.push_back(FW'(1));
        in_data = FW'(9);
        cyc(1);
        in_toggle = ~in_toggle;
        cyc(2);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        cyc(1);
        check("t4_level", 64'(level), 8);
        check("t4_lost", 64'(lost_frames), 0);
        check("t4_sticky", 64'(ovf_sticky), 0);
        check("t4_total", 64'(total_frames), st(9));
        for (int i = 2; i <= 9; i++) expQ.push_back(FW'(i));
        drain();

        // flush coincident with a write at level 5
        for (int i = 1; i <= 5; i++) sendFrame(FW'(i));
        check("t5_level_before", 64'(level), 5);
        totalSnap = total_frames;
        in_data = FW'(6);
        cyc(1);
        in_toggle = ~in_toggle;
        cyc(2);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("t5_level", 64'(level), 0);
        check("t5_valid", 64'(out_valid), 0);
        check("t5_total", 64'(total_frames), st(64'(totalSnap) + 1));
        check("t5_total_abs", 64'(total_frames), st(15));
        check("t5_lost", 64'(lost_frames), 0);
        check("t5_high_water", 64'(high_water), st(8));
        cyc(2);
        sendFrame(16'hA5);
        expQ.push_back(16'hA5);
        drain();

        // async reset mid-burst at level 4
        for (int i = 1; i <= 4; i++) sendFrame(FW'(16'h40 + i));
        check("t6_level_before", 64'(level), 4);
        rst = 1'b1;
        in_toggle = 1'b0;
        #1;
        check("t6_rst_level", 64'(level), 0);
        check("t6_rst_valid", 64'(out_valid), 0);
        check("t6_rst_data", 64'(out_data), 0);
        check("t6_rst_full", 64'(full), 0);
        check("t6_rst_activity", 64'(activity), 0);
        check("t6_rst_total", 64'(total_frames), 0);
        check("t6_rst_high_water", 64'(high_water), 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        in_data = 16'h77;
        cyc(1);
        in_toggle = ~in_toggle;
        cyc(2);
        check("t6_activity_2clk", 64'(activity), 0);
        cyc(1);
        check("t6_activity_3clk", 64'(activity), 1);
        check("t6_level_write", 64'(level), 1);
        check("t6_valid_write_edge", 64'(out_valid), 0);
        cyc(1);
        check("t6_valid_plus1", 64'(out_valid), 0);
        cyc(1);
        check("t6_valid_plus2", 64'(out_valid), 1);
        check("t6_head", 64'(out_data), 64'h77);
        check("t6_total", 64'(total_frames), st(1));
        expQ.push_back(16'h77);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
